// File: rtl/ram_master_pkg.sv
// Shared encodings for the ram_master load/store block: access sizes, FSM states,
// byte-lane enable patterns and the alignment rule.
package ram_master_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StAccess = 2'd1;
  localparam state_t StWait   = 2'd2;
  localparam state_t StResp   = 2'd3;

  localparam logic [3:0] LANE_BYTE = 4'b0001;
  localparam logic [3:0] LANE_HALF = 4'b0011;
  localparam logic [3:0] LANE_WORD = 4'b1111;

  // Reserved size or an access that straddles its natural alignment.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] lane);
    return (size == SIZE_RSVD) ||
           ((size == SIZE_HALF) && lane[0]) ||
           ((size == SIZE_WORD) && (lane != 2'd0));
  endfunction

endpackage

// File: rtl/ram_lane_align.sv
// Byte-lane steering: store enables/data replication and load extraction with
// sign or zero extension.
module ram_lane_align
  import ram_master_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_lane_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_we_o,
  output logic [31:0] st_data_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_lane_i,
  input  logic        ld_signed_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_we_o   = 4'b0000;
    st_data_o = st_data_i;
    case (st_size_i)
      SIZE_BYTE: begin
        st_we_o   = LANE_BYTE << st_lane_i;
        st_data_o = {4{st_data_i[7:0]}};
      end
      SIZE_HALF: begin
        st_we_o   = LANE_HALF << st_lane_i;
        st_data_o = {2{st_data_i[15:0]}};
      end
      SIZE_WORD: st_we_o = LANE_WORD;
      default:   st_we_o = 4'b0000;
    endcase
  end

  assign ld_shifted = ld_raw_i >> {ld_lane_i, 3'b000};

  always_comb begin
    ld_data_o = ld_shifted;
    case (ld_size_i)
      SIZE_BYTE: ld_data_o = {{24{ld_signed_i & ld_shifted[7]}}, ld_shifted[7:0]};
      SIZE_HALF: ld_data_o = {{16{ld_signed_i & ld_shifted[15]}}, ld_shifted[15:0]};
      default:   ld_data_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/ram_master.sv
// Single-outstanding load/store master in front of a synchronous word RAM with
// configurable read latency; one response pulse per accepted request.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int unsigned RAM_AW   = 10,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [1:0] WaitInit = 2'(READ_LAT - 1);

  state_t            state_q, state_d;
  logic              ready_q;
  logic              ram_en_q, ram_en_d;
  logic [3:0]        ram_we_q, ram_we_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        lane_q, lane_d;
  logic              signed_q, signed_d;
  logic [1:0]        wait_q, wait_d;

  logic              accept;
  logic              req_err;
  logic [3:0]        st_we;
  logic [31:0]       st_data;
  logic [31:0]       ld_data;

  assign accept  = req_valid && ready_q;
  assign req_err = size_misaligned(req_size, req_addr[1:0]) ||
                   ((req_addr >> (RAM_AW + 2)) != 32'd0);

  // Store steering uses the live request; load extraction uses the captured fields.
  ram_lane_align u_align (
    .st_size_i   (req_size),
    .st_lane_i   (req_addr[1:0]),
    .st_data_i   (req_wdata),
    .st_we_o     (st_we),
    .st_data_o   (st_data),
    .ld_size_i   (size_q),
    .ld_lane_i   (lane_q),
    .ld_signed_i (signed_q),
    .ld_raw_i    (ram_rdata),
    .ld_data_o   (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 4'b0000;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'd0;
    we_d        = we_q;
    size_d      = size_q;
    lane_d      = lane_q;
    signed_d    = signed_q;
    wait_d      = wait_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          we_d     = req_we;
          size_d   = req_size;
          lane_d   = req_addr[1:0];
          signed_d = req_signed;
          if (req_err) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = StAccess;
            ram_en_d    = 1'b1;
            ram_addr_d  = req_addr[RAM_AW+1:2];
            ram_we_d    = req_we ? st_we : 4'b0000;
            ram_wdata_d = st_data;
          end
        end
      end
      StAccess: begin
        if (we_q) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = StWait;
          wait_d  = WaitInit;
        end
      end
      StWait: begin
        // The final WAIT cycle is the one in which the RAM data is valid.
        if (wait_q == 2'd0) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ld_data;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ready_q     <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 4'b0000;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      we_q        <= 1'b0;
      size_q      <= SIZE_BYTE;
      lane_q      <= 2'd0;
      signed_q    <= 1'b0;
      wait_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      ready_q     <= (state_d == StIdle);
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      we_q        <= we_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      signed_q    <= signed_d;
      wait_q      <= wait_d;
    end
  end

  assign req_ready = ready_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ram_master.sv
// Bench for ram_master: instance 0 has READ_LAT=1, instance 1 has READ_LAT=3, each
// with its own latency-accurate RAM model; responses checked against a queue.
module tb_ram_master;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        preload;
  int          cyc;
  int          checks;
  int          errors;

  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [1:0]  req_size   [2];
  logic        req_signed [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];
  logic        ram_en     [2];
  logic [3:0]  ram_we     [2];
  logic [9:0]  ram_addr   [2];
  logic [31:0] ram_wdata  [2];
  logic [31:0] ram_rdata  [2];

  logic [31:0] ref_mem [2][1024];
  exp_t        sb0 [$];
  exp_t        sb1 [$];

  localparam logic [31:0] LD_ADDR [9] = '{32'h12, 32'h12, 32'h12, 32'h10, 32'h10,
                                          32'h11, 32'h13, 32'h10, 32'h40};
  localparam logic [1:0]  LD_SIZE [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2};
  localparam logic        LD_SGN  [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h1280FF00;
    return (32'(i) * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [1:0] size, input logic sgn);
    logic [31:0] s;
    s = w >> (8 * lane);
    if (size == 2'd0) return sgn ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
    if (size == 2'd1) return sgn ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
    return w;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int Lat = (g == 0) ? 1 : 3;
    logic [31:0] pipe_d [4];
    logic        pipe_v [4];
    logic [31:0] mem    [1024];

    ram_master #(.RAM_AW(10), .READ_LAT(Lat)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_size   (req_size[g]),
      .req_signed (req_signed[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g]),
      .ram_en     (ram_en[g]),
      .ram_we     (ram_we[g]),
      .ram_addr   (ram_addr[g]),
      .ram_wdata  (ram_wdata[g]),
      .ram_rdata  (ram_rdata[g])
    );

    // Read data is only valid exactly Lat cycles after the strobe; garbage otherwise.
    always @(posedge clk) begin
      if (preload) begin
        for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      end else if (ram_en[g] === 1'b1) begin
        for (int b = 0; b < 4; b++)
          if (ram_we[g][b]) mem[ram_addr[g]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
      end
      pipe_v[0] <= (ram_en[g] === 1'b1) && (ram_we[g] == 4'b0000);
      pipe_d[0] <= mem[ram_addr[g]];
      for (int k = 1; k < 4; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_d[k] <= pipe_d[k-1];
      end
    end
    assign ram_rdata[g] = (pipe_v[Lat-1] === 1'b1) ? pipe_d[Lat-1] : 32'h5A5A5A5A;
  end

  // Response scoreboard: every rsp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rsp_valid[d] === 1'b1) begin
        checks++;
        if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
          errors++;
          $display("FAIL rsp_unexpected dut%0d cyc %0d got rsp_valid=1 required none", d, cyc);
        end else begin
          if (d == 0) e = sb0.pop_front();
          else        e = sb1.pop_front();
          if (cyc !== e.cyc) begin
            errors++;
            $display("FAIL rsp_cycle dut%0d got %0d required %0d", d, cyc, e.cyc);
          end
          checks++;
          if (rsp_err[d] !== e.err) begin
            errors++;
            $display("FAIL rsp_err dut%0d got %0b required %0b", d, rsp_err[d], e.err);
          end
          checks++;
          if (rsp_rdata[d] !== e.rdata) begin
            errors++;
            $display("FAIL rsp_rdata dut%0d got %h required %h", d, rsp_rdata[d], e.rdata);
          end
        end
      end
    end
  end

  // Drives one request, waits (bounded) for acceptance, queues the expected response
  // and checks the RAM strobe in the cycle after acceptance. Returns at that cycle.
  task automatic issue(input int d, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit keep,
                       output int acc);
    exp_t        e;
    logic        err;
    logic [1:0]  lane;
    logic [3:0]  xwe;
    logic [31:0] xwd;
    logic [9:0]  idx;
    lane = addr[1:0];
    idx  = addr[11:2];
    err  = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && lane != 2'd0) ||
           (addr[31:12] != 20'd0);
    case (size)
      2'd0:    begin xwe = 4'b0001 << lane; xwd = {4{wdata[7:0]}}; end
      2'd1:    begin xwe = 4'b0011 << lane; xwd = {2{wdata[15:0]}}; end
      default: begin xwe = 4'b1111;         xwd = wdata;            end
    endcase
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d] = we;
    req_size[d] = size;
    req_signed[d] = sgn;
    req_addr[d] = addr;
    req_wdata[d] = wdata;
    acc = -1;
    for (int t = 0; t < 40; t++) begin
      if (req_ready[d] === 1'b1) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL accept_timeout dut%0d got no req_ready required acceptance", d);
      req_valid[d] = 1'b0;
      return;
    end
    e.err   = err;
    e.rdata = (err || we) ? 32'd0 : model_load(ref_mem[d][idx], lane, size, sgn);
    e.cyc   = err ? acc + 1 : (we ? acc + 2 : acc + 2 + ((d == 0) ? 1 : 3));
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    @(negedge clk);
    if (!keep) req_valid[d] = 1'b0;
    checks++;
    if (ram_en[d] !== !err) begin
      errors++;
      $display("FAIL ram_en dut%0d got %0b required %0b", d, ram_en[d], !err);
    end
    if (!err) begin
      checks++;
      if (ram_addr[d] !== idx) begin
        errors++;
        $display("FAIL ram_addr dut%0d got %h required %h", d, ram_addr[d], idx);
      end
      checks++;
      if (ram_we[d] !== (we ? xwe : 4'b0000)) begin
        errors++;
        $display("FAIL ram_we dut%0d got %b required %b", d, ram_we[d], we ? xwe : 4'b0000);
      end
      if (we) begin
        checks++;
        if (ram_wdata[d] !== xwd) begin
          errors++;
          $display("FAIL ram_wdata dut%0d got %h required %h", d, ram_wdata[d], xwd);
        end
        for (int b = 0; b < 4; b++)
          if (xwe[b]) ref_mem[d][idx][8*b +: 8] = xwd[8*b +: 8];
      end
    end
  endtask

  task automatic check_idle_outputs(input int d, input string tag);
    checks++;
    if (req_ready[d] !== 1'b0 || ram_en[d] !== 1'b0 || ram_we[d] !== 4'b0000 ||
        ram_addr[d] !== 10'd0 || ram_wdata[d] !== 32'd0 || rsp_valid[d] !== 1'b0 ||
        rsp_err[d] !== 1'b0 || rsp_rdata[d] !== 32'd0) begin
      errors++;
      $display("FAIL %s dut%0d got rdy=%0b en=%0b we=%b addr=%h wd=%h rv=%0b re=%0b rd=%h required all 0",
               tag, d, req_ready[d], ram_en[d], ram_we[d], ram_addr[d], ram_wdata[d],
               rsp_valid[d], rsp_err[d], rsp_rdata[d]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      req_valid[d] = 1'b0;
      req_we[d] = 1'b0;
      req_size[d] = 2'd0;
      req_signed[d] = 1'b0;
      req_addr[d] = 32'd0;
      req_wdata[d] = 32'd0;
      for (int i = 0; i < 1024; i++) ref_mem[d][i] = init_word(i);
    end
    preload = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) check_idle_outputs(d, "reset_state");
    preload = 1'b0;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_reset dut%0d got %0b required 1", d, req_ready[d]);
      end
    end
  endtask

  task automatic test_loads();
    int acc;
    for (int i = 0; i < 9; i++) issue(0, 1'b0, LD_SIZE[i], LD_SGN[i], LD_ADDR[i], 32'd0, 0, acc);
    issue(1, 1'b0, 2'd0, 1'b1, 32'h12, 32'd0, 0, acc);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h80, 32'd0, 0, acc);
  endtask

  task automatic test_stores();
    int acc;
    issue(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, acc);
    @(negedge clk);
    checks++;
    if (ram_en[0] !== 1'b0 || ram_we[0] !== 4'b0000) begin
      errors++;
      $display("FAIL ram_en_after_access got en=%0b we=%b required 0", ram_en[0], ram_we[0]);
    end
    issue(0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 0, acc);
    issue(0, 1'b1, 2'd1, 1'b0, 32'h16, 32'h1234BEEF, 0, acc);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, acc);
    issue(0, 1'b0, 2'd1, 1'b1, 32'h16, 32'd0, 0, acc);
  endtask

  task automatic test_errors();
    int acc;
    issue(0, 1'b0, 2'd1, 1'b0, 32'h11, 32'd0, 0, acc);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h1000, 32'd0, 0, acc);
    issue(0, 1'b0, 2'd3, 1'b0, 32'h20, 32'd0, 0, acc);
    issue(0, 1'b1, 2'd2, 1'b0, 32'h22, 32'hCAFEF00D, 0, acc);
    issue(0, 1'b1, 2'd0, 1'b0, 32'hFFFF_FFFC, 32'h11, 0, acc);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 0, acc);
  endtask

  task automatic test_back_to_back();
    int a1, a2;
    issue(0, 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, 1, a1);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h34, 32'd0, 0, a2);
    checks++;
    if (a2 !== a1 + 4) begin
      errors++;
      $display("FAIL back_to_back_accept got %0d required %0d", a2, a1 + 4);
    end
  endtask

  task automatic test_random();
    int acc;
    logic [1:0]  size;
    logic [31:0] addr;
    for (int i = 0; i < 24; i++) begin
      size = 2'($urandom_range(0, 2));
      addr = 32'($urandom_range(0, 255));
      if (size == 2'd1) addr[0] = 1'b0;
      if (size == 2'd2) addr[1:0] = 2'd0;
      issue(i % 2, 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom, 0,
            acc);
    end
  endtask

  task automatic test_reset_mid();
    int acc, acc2, rel;
    issue(1, 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, 0, acc);
    @(negedge clk);
    rst_n[1] = 1'b0;
    sb1.delete();
    @(negedge clk);
    check_idle_outputs(1, "reset_mid_state");
    @(negedge clk);
    check_idle_outputs(1, "reset_mid_hold");
    rst_n[1] = 1'b1;
    rel = cyc;
    issue(1, 1'b0, 2'd2, 1'b0, 32'h34, 32'd0, 0, acc2);
    checks++;
    if (acc2 !== rel + 1) begin
      errors++;
      $display("FAIL accept_after_reset got %0d required %0d", acc2, rel + 1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    for (int t = 0; t < 60 && (sb0.size() != 0 || sb1.size() != 0); t++) @(negedge clk);
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("FAIL rsp_missing got %0d/%0d pending required 0", sb0.size(), sb1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
